// File: rtl/reg_decoder.sv
// Registered N-to-2^N one-hot decoder with a valid/ready command input.
// Latched mode holds the decode; pulse mode asserts it for PULSE_W cycles.
module reg_decoder #(
  parameter int unsigned N       = 2,
  parameter int unsigned PULSE_W = 1,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clr,
  input  logic                 mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         sel,
  output logic [(2**N)-1:0]    out,
  output logic                 out_valid,
  output logic [CNT_W-1:0]     acc_cnt
);

  localparam int unsigned OUT_W  = 2 ** N;
  localparam int unsigned PCNT_W = 8;

  typedef enum logic [0:0] {
    StIdle,
    StPulse
  } state_e;

  state_e              state_q, state_d;
  logic [OUT_W-1:0]    out_q, out_d;
  logic                out_valid_q, out_valid_d;
  logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
  logic [CNT_W-1:0]    acc_cnt_q, acc_cnt_d;
  logic [OUT_W-1:0]    one_hot;
  logic                accept;

  always_comb begin
    one_hot      = '0;
    one_hot[sel] = 1'b1;
  end

  // Ready depends only on state and enable, never on in_valid.
  assign in_ready = en & ~rst & (state_q == StIdle);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    pcnt_d      = pcnt_q;
    acc_cnt_d   = acc_cnt_q;

    if (clr) begin
      // Clear beats a same-cycle command: nothing is accepted or counted.
      state_d     = StIdle;
      out_d       = '0;
      out_valid_d = 1'b0;
      pcnt_d      = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            out_d       = one_hot;
            out_valid_d = 1'b1;
            acc_cnt_d   = acc_cnt_q + CNT_W'(1);
            if (mode) begin
              state_d = StPulse;
              pcnt_d  = PCNT_W'(PULSE_W - 1);
            end
          end
        end
        StPulse: begin
          if (pcnt_q == '0) begin
            state_d     = StIdle;
            out_d       = '0;
            out_valid_d = 1'b0;
          end else begin
            pcnt_d = pcnt_q - PCNT_W'(1);
          end
        end
        default: begin
          state_d     = StIdle;
          out_d       = '0;
          out_valid_d = 1'b0;
          pcnt_d      = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      pcnt_q      <= '0;
      acc_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      pcnt_q      <= pcnt_d;
      acc_cnt_q   <= acc_cnt_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign acc_cnt   = acc_cnt_q;

  // A valid output is always exactly one-hot; an invalid one is all zero.
  a_onehot_when_valid: assert property (@(posedge clk) disable iff (rst)
    out_valid |-> $onehot(out));
  a_zero_when_invalid: assert property (@(posedge clk) disable iff (rst)
    !out_valid |-> (out == '0));

endmodule

// File: tb/tb_reg_decoder.sv
// Directed bench for reg_decoder: a narrow pulse-width-3 instance and a wide
// 16-output instance share clock and control inputs.
module tb_reg_decoder;

  logic        clk;
  logic        rst;
  logic        en;
  logic        clr;
  logic        mode;

  logic        in_valid_a;
  logic        in_ready_a;
  logic [1:0]  sel_a;
  logic [3:0]  out_a;
  logic        out_valid_a;
  logic [7:0]  acc_a;

  logic        in_valid_b;
  logic        in_ready_b;
  logic [3:0]  sel_b;
  logic [15:0] out_b;
  logic        out_valid_b;
  logic [7:0]  acc_b;

  int n_tests;
  int n_fail;

  reg_decoder #(
    .N       (2),
    .PULSE_W (3),
    .CNT_W   (8)
  ) u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .clr       (clr),
    .mode      (mode),
    .in_valid  (in_valid_a),
    .in_ready  (in_ready_a),
    .sel       (sel_a),
    .out       (out_a),
    .out_valid (out_valid_a),
    .acc_cnt   (acc_a)
  );

  reg_decoder #(
    .N       (4),
    .PULSE_W (1),
    .CNT_W   (8)
  ) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .clr       (clr),
    .mode      (mode),
    .in_valid  (in_valid_b),
    .in_ready  (in_ready_b),
    .sel       (sel_b),
    .out       (out_b),
    .out_valid (out_valid_b),
    .acc_cnt   (acc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; in_valid_a = 1'b1; sel_a = 2'd2;
    tick();
    tick();
    #1;
    n_tests++;
    if (out_a !== 4'b0000) begin
      n_fail++; $display("FAIL reset_out: got %b expected %b", out_a, 4'b0000);
    end
    n_tests++;
    if (out_valid_a !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid_a);
    end
    n_tests++;
    if (acc_a !== 8'd0) begin
      n_fail++; $display("FAIL reset_acc: got %0d expected 0", acc_a);
    end
    n_tests++;
    if (in_ready_a !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready_a);
    end
    rst = 1'b0; in_valid_a = 1'b0;
    #1;
    n_tests++;
    if (in_ready_a !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready_a);
    end
  endtask

  task automatic test_latched();
    logic [3:0] exp_oh [4];
    exp_oh = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    mode = 1'b0; in_valid_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel_a = 2'(i);
      #1;
      n_tests++;
      if (in_ready_a !== 1'b1) begin
        n_fail++; $display("FAIL latched_in_ready[%0d]: got %b expected 1", i, in_ready_a);
      end
      tick();
      n_tests++;
      if (out_a !== exp_oh[i] || out_valid_a !== 1'b1) begin
        n_fail++;
        $display("FAIL latched_out[%0d]: got %b/%b expected %b/1", i, out_a, out_valid_a,
                 exp_oh[i]);
      end
    end
    in_valid_a = 1'b0;
    tick();
    tick();
    n_tests++;
    if (out_a !== 4'b1000 || acc_a !== 8'd4) begin
      n_fail++; $display("FAIL latched_hold: got out=%b acc=%0d expected 1000/4", out_a, acc_a);
    end
  endtask

  // Leaves a second pulse in flight at its first cycle for test_clear_mid_pulse.
  task automatic test_pulse();
    mode = 1'b1; sel_a = 2'd2; in_valid_a = 1'b1;
    tick();
    for (int c = 1; c <= 3; c++) begin
      n_tests++;
      if (out_a !== 4'b0100 || out_valid_a !== 1'b1 || in_ready_a !== 1'b0 ||
          acc_a !== 8'd5) begin
        n_fail++;
        $display("FAIL pulse_T+%0d: got out=%b v=%b rdy=%b acc=%0d expected 0100/1/0/5",
                 c, out_a, out_valid_a, in_ready_a, acc_a);
      end
      tick();
    end
    n_tests++;
    if (out_a !== 4'b0000 || out_valid_a !== 1'b0 || in_ready_a !== 1'b1 || acc_a !== 8'd5)
    begin
      n_fail++;
      $display("FAIL pulse_T+4: got out=%b v=%b rdy=%b acc=%0d expected 0000/0/1/5",
               out_a, out_valid_a, in_ready_a, acc_a);
    end
    tick();
    n_tests++;
    if (out_a !== 4'b0100 || acc_a !== 8'd6) begin
      n_fail++; $display("FAIL pulse_reaccept: got out=%b acc=%0d expected 0100/6", out_a, acc_a);
    end
    in_valid_a = 1'b0;
  endtask

  task automatic test_clear_mid_pulse();
    tick();
    clr = 1'b1; in_valid_a = 1'b1; sel_a = 2'd1; mode = 1'b0;
    tick();
    clr = 1'b0; in_valid_a = 1'b0;
    n_tests++;
    if (out_a !== 4'b0000 || out_valid_a !== 1'b0 || acc_a !== 8'd6) begin
      n_fail++;
      $display("FAIL clr_mid_pulse: got out=%b v=%b acc=%0d expected 0000/0/6",
               out_a, out_valid_a, acc_a);
    end
    #1;
    n_tests++;
    if (in_ready_a !== 1'b1) begin
      n_fail++; $display("FAIL clr_idle_state: got in_ready=%b expected 1", in_ready_a);
    end
    in_valid_a = 1'b1; sel_a = 2'd3;
    tick();
    clr = 1'b1; sel_a = 2'd0;
    #1;
    tick();
    clr = 1'b0; in_valid_a = 1'b0;
    n_tests++;
    if (out_a !== 4'b0000 || out_valid_a !== 1'b0 || acc_a !== 8'd7) begin
      n_fail++;
      $display("FAIL clr_beats_cmd: got out=%b v=%b acc=%0d expected 0000/0/7",
               out_a, out_valid_a, acc_a);
    end
  endtask

  task automatic test_mode_change();
    mode = 1'b0; sel_a = 2'd1; in_valid_a = 1'b1;
    tick();
    in_valid_a = 1'b0; mode = 1'b1;
    tick();
    tick();
    n_tests++;
    if (out_a !== 4'b0010 || out_valid_a !== 1'b1 || acc_a !== 8'd8) begin
      n_fail++;
      $display("FAIL mode_change_hold: got out=%b v=%b acc=%0d expected 0010/1/8",
               out_a, out_valid_a, acc_a);
    end
    sel_a = 2'd0; in_valid_a = 1'b1;
    tick();
    in_valid_a = 1'b0; en = 1'b0;
    n_tests++;
    if (out_a !== 4'b0001 || acc_a !== 8'd9) begin
      n_fail++; $display("FAIL pulse_replaces: got out=%b acc=%0d expected 0001/9", out_a, acc_a);
    end
    tick();
    tick();
    n_tests++;
    if (out_a !== 4'b0001) begin
      n_fail++; $display("FAIL pulse_en_low_T+3: got %b expected 0001", out_a);
    end
    tick();
    n_tests++;
    if (out_a !== 4'b0000 || out_valid_a !== 1'b0) begin
      n_fail++; $display("FAIL pulse_en_low_end: got %b/%b expected 0000/0", out_a, out_valid_a);
    end
  endtask

  task automatic test_enable();
    en = 1'b0; in_valid_a = 1'b1; sel_a = 2'd3; mode = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_tests++;
      if (in_ready_a !== 1'b0) begin
        n_fail++; $display("FAIL en_low_ready[%0d]: got %b expected 0", i, in_ready_a);
      end
      tick();
      n_tests++;
      if (out_a !== 4'b0000 || acc_a !== 8'd9) begin
        n_fail++;
        $display("FAIL en_low_hold[%0d]: got out=%b acc=%0d expected 0000/9", i, out_a, acc_a);
      end
    end
    en = 1'b1;
    tick();
    in_valid_a = 1'b0;
    n_tests++;
    if (out_a !== 4'b1000 || acc_a !== 8'd10) begin
      n_fail++; $display("FAIL en_high_accept: got out=%b acc=%0d expected 1000/10", out_a, acc_a);
    end
  endtask

  task automatic test_wrap();
    rst = 1'b1;
    tick();
    rst = 1'b0; mode = 1'b0; in_valid_a = 1'b1;
    for (int i = 0; i < 256; i++) begin
      sel_a = 2'(i);
      tick();
      if (i == 254) begin
        n_tests++;
        if (acc_a !== 8'd255) begin
          n_fail++; $display("FAIL wrap_255: got %0d expected 255", acc_a);
        end
      end
    end
    n_tests++;
    if (acc_a !== 8'd0 || out_a !== 4'b1000) begin
      n_fail++; $display("FAIL wrap_0: got acc=%0d out=%b expected 0/1000", acc_a, out_a);
    end
    for (int i = 0; i < 3; i++) tick();
    in_valid_a = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    n_tests++;
    if (acc_a !== 8'd3 || out_a !== 4'b0000) begin
      n_fail++; $display("FAIL clr_keeps_acc: got acc=%0d out=%b expected 3/0000", acc_a, out_a);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if (acc_a !== 8'd0) begin
      n_fail++; $display("FAIL rst_clears_acc: got %0d expected 0", acc_a);
    end
  endtask

  task automatic test_wide();
    en = 1'b1; mode = 1'b1; sel_b = 4'd15; in_valid_b = 1'b1;
    tick();
    in_valid_b = 1'b0;
    n_tests++;
    if (out_b !== 16'h8000 || out_valid_b !== 1'b1 || in_ready_b !== 1'b0 || acc_b !== 8'd1)
    begin
      n_fail++;
      $display("FAIL wide_pulse: got out=%h v=%b rdy=%b acc=%0d expected 8000/1/0/1",
               out_b, out_valid_b, in_ready_b, acc_b);
    end
    tick();
    n_tests++;
    if (out_b !== 16'h0000 || out_valid_b !== 1'b0 || in_ready_b !== 1'b1) begin
      n_fail++;
      $display("FAIL wide_pulse_end: got out=%h v=%b rdy=%b expected 0000/0/1",
               out_b, out_valid_b, in_ready_b);
    end
    sel_b = 4'd5; in_valid_b = 1'b1;
    tick();
    n_tests++;
    if (out_b !== 16'h0020) begin
      n_fail++; $display("FAIL wide_b2b_first: got %h expected 0020", out_b);
    end
    tick();
    n_tests++;
    if (out_b !== 16'h0000 || out_valid_b !== 1'b0) begin
      n_fail++; $display("FAIL wide_b2b_gap: got %h/%b expected 0000/0", out_b, out_valid_b);
    end
    tick();
    in_valid_b = 1'b0;
    n_tests++;
    if (out_b !== 16'h0020 || acc_b !== 8'd3) begin
      n_fail++; $display("FAIL wide_b2b_second: got out=%h acc=%0d expected 0020/3", out_b, acc_b);
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b1; en = 1'b0; clr = 1'b0; mode = 1'b0;
    in_valid_a = 1'b0; sel_a = '0;
    in_valid_b = 1'b0; sel_b = '0;
    test_reset();
    test_latched();
    test_pulse();
    test_clear_mid_pulse();
    test_mode_change();
    test_enable();
    test_wrap();
    test_wide();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
